hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 2, the width of each per-register in-flight write counter (max in-flight = 2^CNT_WIDTH-1).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port id_valid_i  input  1  the decode stage holds an instruction.
REQ-005 SHALL have port reg1_re_i / reg2_re_i  input  1 each  source-operand read enables from decode.
REQ-006 SHALL have port reg1_raddr_i / reg2_raddr_i  input  `RADDR_WIDTH each  source register addresses.
REQ-007 SHALL have port reg_we_i  input  1  decoded instruction writes a destination register.
REQ-008 SHALL have port reg_waddr_i  input  `RADDR_WIDTH  destination register address.
REQ-009 SHALL have port wb_we_i  input  1  writeback retires a register write this cycle.
REQ-010 SHALL have port wb_waddr_i  input  `RADDR_WIDTH  retiring destination address.
REQ-011 SHALL have port flush_i  input  1  pipeline flush; all in-flight writes are abandoned.
REQ-012 SHALL have port issue_o  output  1  decoded instruction advances to execute this cycle.
REQ-013 SHALL have port stall_o  output  1  decode held this cycle because of a hazard.
REQ-014 SHALL have port err_o  output  1  sticky: retire seen for a register with zero in-flight count.
REQ-015 SHALL have port stall_cnt_o  output  32  saturating count of stall cycles since reset.

Function
REQ-016 SHALL keep one CNT_WIDTH-bit in-flight counter per architectural register 1..31; register x0 is never tracked and never causes a hazard.
REQ-017 SHALL assert hazard combinationally when id_valid_i and (reg1_re_i with count[reg1_raddr_i]!=0, or reg2_re_i with count[reg2_raddr_i]!=0, or reg_we_i with count[reg_waddr_i] at maximum).
REQ-018 SHALL drive issue_o = id_valid_i & ~hazard & ~flush_i and stall_o = id_valid_i & hazard & ~flush_i, both combinational with zero latency.
REQ-019 SHALL increment count[reg_waddr_i] on the clock edge after issue_o with reg_we_i and reg_waddr_i!=0.
REQ-020 SHALL decrement count[wb_waddr_i] on the clock edge when wb_we_i, wb_waddr_i!=0 and count is nonzero.
REQ-021 SHALL leave the count unchanged when an increment and a decrement target the same register in the same cycle.
REQ-022 SHALL NOT forward retirements: a source whose count is 1 and is retiring in the current cycle still stalls that cycle and issues in the next cycle.
REQ-023 SHALL ignore wb_we_i to a register whose count is zero, leaving the count at zero and setting err_o, which stays 1 until reset.
REQ-024 SHALL clear all counters on flush_i at the next edge, with flush taking priority over simultaneous issue and retire.
REQ-025 SHALL increment stall_cnt_o on every cycle stall_o is 1 and hold it at 32'hFFFFFFFF once reached.

Reset
REQ-026 SHALL, while rst is 1 at a clock edge, clear every counter, err_o and stall_cnt_o; issue_o and stall_o SHALL read 0 while rst is 1.
REQ-027 SHALL, when reset is applied mid-operation, discard all in-flight state with no residual hazard in the first cycle after rst falls.

Structure
REQ-028 SHALL take `RADDR_WIDTH, `ZERO_REG, `WRITE_ENABLE and `READ_ENABLE from the shared defines.v; no new global macros are needed.
REQ-029 SHALL implement the counter array as one sub-module, scoreboard_cnt, with inc/dec address ports, a clear input and a count-read output per source port.

Verification
REQ-030 SHALL cover: issue with x5 written (we, waddr=5) -> next cycle, an instruction reading rs1=5 gives stall_o=1; after wb_we_i waddr=5 it issues on the following cycle; stall_cnt_o advances by the number of stalled cycles.
REQ-031 SHALL cover: an instruction writing rd=0 followed by one reading rs1=0 -> no stall, and the x0 counter stays 0.
REQ-032 SHALL cover: three back-to-back writes to x7 with CNT_WIDTH=2 -> a fourth writer to x7 stalls until one wb to x7 retires.
REQ-033 SHALL cover: issue to x9 and wb of x9 in the same cycle with count=1 -> count stays 1; wb to x3 with count=0 -> err_o=1 and sticky.
REQ-034 SHALL cover: flush_i asserted with a pending x4 while an issue is requested -> issue_o=0, all counts 0 next cycle, and a read of x4 issues immediately.
REQ-035 SHALL cover: rst asserted with pending writes and stall_cnt_o=10 -> all outputs 0 after the edge and no stall in the first cycle after release.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the register hazard scoreboard.
// Mirrors the shared register-file defines (RADDR_WIDTH, ZERO_REG,
// WRITE_ENABLE, READ_ENABLE) as package constants so every file in this
// slice uses one source of truth without a global include.
package hazard_scoreboard_pkg;

    localparam int unsigned RADDR_WIDTH     = 5;
    localparam int unsigned NUM_REGS        = 1 << RADDR_WIDTH;
    localparam int unsigned STALL_CNT_WIDTH = 32;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG     = '0;
    localparam logic                   WRITE_ENABLE = 1'b1;
    localparam logic                   READ_ENABLE  = 1'b1;

    typedef logic [RADDR_WIDTH-1:0] raddr_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback <-> scoreboard interface.
//   master : decode and writeback side (drives requests, observes verdict)
//   slave  : the scoreboard (observes requests, drives issue/stall/status)
// Signals: id_valid_i, reg1/2_re_i, reg1/2_raddr_i, reg_we_i, reg_waddr_i,
//          wb_we_i, wb_waddr_i, flush_i -> scoreboard
//          issue_o, stall_o, err_o, stall_cnt_o <- scoreboard
interface hazard_scoreboard_if;
    import hazard_scoreboard_pkg::*;

    logic                       id_valid_i;
    logic                       reg1_re_i;
    logic                       reg2_re_i;
    raddr_t                     reg1_raddr_i;
    raddr_t                     reg2_raddr_i;
    logic                       reg_we_i;
    raddr_t                     reg_waddr_i;
    logic                       wb_we_i;
    raddr_t                     wb_waddr_i;
    logic                       flush_i;
    logic                       issue_o;
    logic                       stall_o;
    logic                       err_o;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_o;

    modport master (
        output id_valid_i, reg1_re_i, reg2_re_i, reg1_raddr_i, reg2_raddr_i,
               reg_we_i, reg_waddr_i, wb_we_i, wb_waddr_i, flush_i,
        input  issue_o, stall_o, err_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, reg1_re_i, reg2_re_i, reg1_raddr_i, reg2_raddr_i,
               reg_we_i, reg_waddr_i, wb_we_i, wb_waddr_i, flush_i,
        output issue_o, stall_o, err_o, stall_cnt_o
    );

endinterface

// File: rtl/hazard_scoreboard_cnt.sv
// scoreboard_cnt: array of per-register in-flight write counters.
// Ports: clk, rst (sync, active-high), clear (drop all in-flight state),
//        inc_en/inc_addr, dec_en/dec_addr (caller guarantees dec only on a
//        nonzero count), four combinational count-read ports.
// Entry 0 is never written, so reads of x0 always return zero.
module scoreboard_cnt
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 inc_en,
    input  raddr_t               inc_addr,
    input  logic                 dec_en,
    input  raddr_t               dec_addr,
    input  raddr_t               rd1_addr,
    input  raddr_t               rd2_addr,
    input  raddr_t               rdw_addr,
    output logic [CNT_WIDTH-1:0] rd1_cnt,
    output logic [CNT_WIDTH-1:0] rd2_cnt,
    output logic [CNT_WIDTH-1:0] rdw_cnt,
    output logic [CNT_WIDTH-1:0] dec_cnt
);

    logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
    logic [NUM_REGS-1:0]  inc_vec;
    logic [NUM_REGS-1:0]  dec_vec;

    // One-hot update selects; x0 is masked so it can never leave zero.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (inc_en) inc_vec[inc_addr] = 1'b1;
        if (dec_en) dec_vec[dec_addr] = 1'b1;
        inc_vec[0] = 1'b0;
        dec_vec[0] = 1'b0;
    end

    // Clear wins over everything; a simultaneous inc and dec cancel out.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
                end
            end
        end
    end

    assign rd1_cnt = cnt_q[rd1_addr];
    assign rd2_cnt = cnt_q[rd2_addr];
    assign rdw_cnt = cnt_q[rdw_addr];
    assign dec_cnt = cnt_q[dec_addr];

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage RAW/write-capacity hazard detector.
// Ports: clk, rst (sync, active-high), bus (hazard_scoreboard_if.slave).
//   issue_o / stall_o are combinational verdicts for the current decode slot;
//   err_o (sticky retire-without-pending) and stall_cnt_o (saturating stall
//   cycle count) are registered.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0]       rs1_cnt;
    logic [CNT_WIDTH-1:0]       rs2_cnt;
    logic [CNT_WIDTH-1:0]       rd_cnt;
    logic [CNT_WIDTH-1:0]       wb_cnt;
    logic                       hazard_c;
    logic                       issue_c;
    logic                       stall_c;
    logic                       inc_en_c;
    logic                       wb_valid_c;
    logic                       dec_en_c;
    logic                       err_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

    scoreboard_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.flush_i),
        .inc_en   (inc_en_c),
        .inc_addr (bus.reg_waddr_i),
        .dec_en   (dec_en_c),
        .dec_addr (bus.wb_waddr_i),
        .rd1_addr (bus.reg1_raddr_i),
        .rd2_addr (bus.reg2_raddr_i),
        .rdw_addr (bus.reg_waddr_i),
        .rd1_cnt  (rs1_cnt),
        .rd2_cnt  (rs2_cnt),
        .rdw_cnt  (rd_cnt),
        .dec_cnt  (wb_cnt)
    );

    // Hazard uses pre-edge counts only, so a same-cycle retire is not forwarded.
    always_comb begin
        hazard_c   = 1'b0;
        issue_c    = 1'b0;
        stall_c    = 1'b0;
        inc_en_c   = 1'b0;
        wb_valid_c = 1'b0;
        dec_en_c   = 1'b0;

        hazard_c = bus.id_valid_i &&
                   (((bus.reg1_re_i == READ_ENABLE) && (rs1_cnt != '0)) ||
                    ((bus.reg2_re_i == READ_ENABLE) && (rs2_cnt != '0)) ||
                    ((bus.reg_we_i == WRITE_ENABLE) && (rd_cnt == CNT_MAX)));
        issue_c    = bus.id_valid_i && !hazard_c && !bus.flush_i && !rst;
        stall_c    = bus.id_valid_i &&  hazard_c && !bus.flush_i && !rst;
        inc_en_c   = issue_c && (bus.reg_we_i == WRITE_ENABLE) &&
                     (bus.reg_waddr_i != ZERO_REG);
        wb_valid_c = bus.wb_we_i && (bus.wb_waddr_i != ZERO_REG);
        dec_en_c   = wb_valid_c && (wb_cnt != '0);
    end

    // Sticky error flag and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (wb_valid_c && (wb_cnt == '0)) err_q <= 1'b1;
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
            end
        end
    end

    assign bus.issue_o     = issue_c;
    assign bus.stall_o     = stall_c;
    assign bus.err_o       = err_q;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// randomized traffic, checked against an array-of-counts reference model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int unsigned CNT_WIDTH = 2;
    localparam int          CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if bus ();

    hazard_scoreboard #(
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit       rst;
        bit       id_valid;
        bit       re1;
        bit [4:0] a1;
        bit       re2;
        bit [4:0] a2;
        bit       we;
        bit [4:0] wa;
        bit       wb;
        bit [4:0] wba;
        bit       flush;
        string    tag;
    } stim_t;

    typedef struct {
        bit        issue;
        bit        stall;
        bit        err;
        bit [31:0] scnt;
        string     tag;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: in-flight writes per register, sticky error, stall total.
    int     m_cnt [32];
    bit     m_err  = 1'b0;
    longint m_scnt = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    function automatic stim_t nop(input string tag);
        stim_t s;
        s.rst = 1'b0; s.id_valid = 1'b0; s.re1 = 1'b0; s.a1 = '0;
        s.re2 = 1'b0; s.a2 = '0; s.we = 1'b0; s.wa = '0;
        s.wb = 1'b0; s.wba = '0; s.flush = 1'b0; s.tag = tag;
        return s;
    endfunction

    // Drive one cycle, queue the expected verdict, then advance the model.
    task automatic step(input stim_t s);
        exp_t e;
        bit   hz;
        bit   inc;
        bit   dec;
        @(posedge clk);
        #1;
        rst              = s.rst;
        bus.id_valid_i   = s.id_valid;
        bus.reg1_re_i    = s.re1;
        bus.reg1_raddr_i = s.a1;
        bus.reg2_re_i    = s.re2;
        bus.reg2_raddr_i = s.a2;
        bus.reg_we_i     = s.we;
        bus.reg_waddr_i  = s.wa;
        bus.wb_we_i      = s.wb;
        bus.wb_waddr_i   = s.wba;
        bus.flush_i      = s.flush;

        hz = s.id_valid && ((s.re1 && m_cnt[s.a1] > 0) ||
                            (s.re2 && m_cnt[s.a2] > 0) ||
                            (s.we && m_cnt[s.wa] == CNT_MAX));
        e.issue = !s.rst && s.id_valid && !hz && !s.flush;
        e.stall = !s.rst && s.id_valid &&  hz && !s.flush;
        e.err   = m_err;
        e.scnt  = 32'(m_scnt);
        e.tag   = s.tag;
        exp_q.push_back(e);

        if (s.rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_err  = 1'b0;
            m_scnt = 0;
        end else begin
            if (s.wb && s.wba != 0 && m_cnt[s.wba] == 0) m_err = 1'b1;
            if (e.stall && m_scnt < 64'hFFFF_FFFF) m_scnt++;
            if (s.flush) begin
                foreach (m_cnt[i]) m_cnt[i] = 0;
            end else begin
                inc = e.issue && s.we && s.wa != 0;
                dec = s.wb && s.wba != 0 && m_cnt[s.wba] > 0;
                if (!(inc && dec && s.wa == s.wba)) begin
                    if (inc) m_cnt[s.wa]++;
                    if (dec) m_cnt[s.wba]--;
                end
            end
        end
    endtask

    // Monitor: DUT presents a verdict every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, "issue_o",     32'(bus.issue_o),  32'(e.issue));
                check(e.tag, "stall_o",     32'(bus.stall_o),  32'(e.stall));
                check(e.tag, "err_o",       32'(bus.err_o),    32'(e.err));
                check(e.tag, "stall_cnt_o", bus.stall_cnt_o,   e.scnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        bus.id_valid_i = 1'b0; bus.reg1_re_i = 1'b0; bus.reg2_re_i = 1'b0;
        bus.reg1_raddr_i = '0; bus.reg2_raddr_i = '0; bus.reg_we_i = 1'b0;
        bus.reg_waddr_i = '0; bus.wb_we_i = 1'b0; bus.wb_waddr_i = '0;
        bus.flush_i = 1'b0;

        s = nop("reset"); s.rst = 1'b1; s.id_valid = 1'b1;
        step(s); step(s);

        // RAW on x5, no forwarding from a same-cycle retire
        s = nop("x5_write");  s.id_valid = 1'b1; s.we = 1'b1; s.wa = 5'd5; step(s);
        s = nop("x5_raw");    s.id_valid = 1'b1; s.re1 = 1'b1; s.a1 = 5'd5;
        step(s); step(s);
        s.tag = "x5_retire_no_fwd"; s.wb = 1'b1; s.wba = 5'd5; step(s);
        s.tag = "x5_issue_after";   s.wb = 1'b0; step(s);

        // x0 is never tracked
        s = nop("x0_write"); s.id_valid = 1'b1; s.we = 1'b1; s.wa = 5'd0; step(s);
        s = nop("x0_read");  s.id_valid = 1'b1; s.re1 = 1'b1; s.a1 = 5'd0; step(s);
        s = nop("x0_read2"); s.id_valid = 1'b1; s.re2 = 1'b1; s.a2 = 5'd0; step(s);

        // x7 capacity limit
        s = nop("x7_write"); s.id_valid = 1'b1; s.we = 1'b1; s.wa = 5'd7;
        step(s); step(s); step(s);
        s.tag = "x7_full_stall"; step(s); step(s);
        s.tag = "x7_full_retire"; s.wb = 1'b1; s.wba = 5'd7; step(s);
        s.tag = "x7_fourth_issue"; s.wb = 1'b0; step(s);
        s = nop("x7_drain"); s.wb = 1'b1; s.wba = 5'd7;
        step(s); step(s); step(s);

        // x9 simultaneous inc/dec, x3 spurious retire
        s = nop("x9_write"); s.id_valid = 1'b1; s.we = 1'b1; s.wa = 5'd9; step(s);
        s.tag = "x9_inc_dec"; s.wb = 1'b1; s.wba = 5'd9; step(s);
        s = nop("x9_still_1"); s.id_valid = 1'b1; s.re1 = 1'b1; s.a1 = 5'd9; step(s);
        s.tag = "x9_retire"; s.wb = 1'b1; s.wba = 5'd9; step(s);
        s.tag = "x9_retire2"; step(s);
        s = nop("x9_clear"); s.id_valid = 1'b1; s.re2 = 1'b1; s.a2 = 5'd9; step(s);
        s = nop("x3_spurious"); s.wb = 1'b1; s.wba = 5'd3; step(s);
        s = nop("err_sticky"); step(s); step(s); step(s);

        // flush beats a simultaneous issue
        s = nop("x4_write"); s.id_valid = 1'b1; s.we = 1'b1; s.wa = 5'd4; step(s);
        s = nop("flush_issue"); s.id_valid = 1'b1; s.we = 1'b1; s.wa = 5'd6;
        s.flush = 1'b1; step(s);
        s = nop("x4_after_flush"); s.id_valid = 1'b1; s.re1 = 1'b1; s.a1 = 5'd4; step(s);
        s = nop("x6_after_flush"); s.id_valid = 1'b1; s.re2 = 1'b1; s.a2 = 5'd6; step(s);

        // mid-operation reset with ten stalls recorded
        s = nop("pre_rst"); s.rst = 1'b1; step(s);
        s = nop("x10_write"); s.id_valid = 1'b1; s.we = 1'b1; s.wa = 5'd10; step(s);
        s = nop("x10_stall"); s.id_valid = 1'b1; s.re1 = 1'b1; s.a1 = 5'd10;
        for (int i = 0; i < 10; i++) step(s);
        s.tag = "rst_mid"; s.rst = 1'b1; step(s);
        s.tag = "rst_release"; s.rst = 1'b0; step(s);

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            s = nop("random");
            s.rst      = ($urandom_range(0, 299) == 0);
            s.flush    = !s.rst && ($urandom_range(0, 39) == 0);
            s.id_valid = ($urandom_range(0, 9) < 8);
            s.re1      = 1'($urandom_range(0, 1));
            s.re2      = 1'($urandom_range(0, 1));
            s.a1       = 5'($urandom_range(0, 7));
            s.a2       = 5'($urandom_range(0, 7));
            s.we       = 1'($urandom_range(0, 1));
            s.wa       = 5'($urandom_range(0, 7));
            s.wba      = 5'($urandom_range(0, 7));
            s.wb       = !s.flush && ($urandom_range(0, 9) < 5) &&
                         (m_cnt[s.wba] > 0 || $urandom_range(0, 99) == 0);
            step(s);
        end

        s = nop("tail"); step(s);
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
